// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory ready handshakes with a bounded wait, and traps on illegal instructions.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4,
    parameter bit ENABLE_JAL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  WBSel,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUctl,
    output logic        illegal,
    output logic        timeout,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam bit                   TO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(MEM_TIMEOUT);

    state_t               state_r, state_s;
    logic [TIMEOUT_W-1:0] cnt_r, cnt_s;
    logic                 illegal_r, illegal_s;
    logic                 timeout_r, timeout_s;

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];

    // f7 only selects SUB for register ops; for I-type it is immediate bits except on shifts
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic [6:0] f7, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b010:  op = ALU_SLT;
            3'b001:  op = ALU_SLL;
            3'b101:  op = f7[5] ? ALU_SRA : ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        case (op)
            OP_R: begin
                if (f7 == F7_ZERO) begin
                    ok = (f3 != 3'b011);
                end else if (f7 == F7_ALT) begin
                    ok = (f3 == 3'b000) || (f3 == 3'b101);
                end else begin
                    ok = 1'b0;
                end
            end
            OP_I: begin
                case (f3)
                    3'b011:  ok = 1'b0;
                    3'b001:  ok = (f7 == F7_ZERO);
                    3'b101:  ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    default: ok = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
            OP_BRANCH:         ok = (f3 == 3'b000) || (f3 == 3'b001);
            OP_JAL:            ok = ENABLE_JAL;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State, wait counter and sticky trap flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            cnt_r     <= '0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            illegal_r <= illegal_s;
            timeout_r <= timeout_s;
        end
    end

    // Next-state and control decode; reset forces every strobe and select low
    always_comb begin
        state_s   = state_r;
        cnt_s     = '0;
        illegal_s = illegal_r;
        timeout_s = timeout_r;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        WBSel     = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUctl    = ALU_AND;
        if (rst) begin
            state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (state_r == S_FETCH) begin
                        MemRead = 1'b1;
                        ALUSrcB = 2'b01;
                        ALUctl  = ALU_ADD;
                    end else if (state_r == S_MEM_RD) begin
                        MemRead = 1'b1;
                        IorD    = 1'b1;
                    end else begin
                        MemWrite = 1'b1;
                        IorD     = 1'b1;
                    end
                    // mem_ready on the timeout cycle still completes the access
                    if (mem_ready) begin
                        if (state_r == S_FETCH) begin
                            IRWrite = 1'b1;
                            PCWrite = 1'b1;
                            state_s = S_DECODE;
                        end else if (state_r == S_MEM_RD) begin
                            state_s = S_WB_MEM;
                        end else begin
                            state_s = S_FETCH;
                        end
                    end else if (TO_EN && (cnt_r == TO_LIM)) begin
                        state_s   = S_TRAP;
                        timeout_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b10;
                    ALUctl  = ALU_ADD;
                    if (!is_legal(opcode_s, f3_s, f7_s)) begin
                        state_s   = S_TRAP;
                        illegal_s = 1'b1;
                    end else begin
                        case (opcode_s)
                            OP_R:              state_s = S_EXEC_R;
                            OP_I:              state_s = S_EXEC_I;
                            OP_LOAD, OP_STORE: state_s = S_MEM_ADDR;
                            OP_BRANCH:         state_s = S_BRANCH;
                            OP_JAL:            state_s = S_JAL;
                            default: begin
                                state_s   = S_TRAP;
                                illegal_s = 1'b1;
                            end
                        endcase
                    end
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUctl  = alu_op(f3_s, f7_s, 1'b1);
                    state_s = S_WB_ALU;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUctl  = alu_op(f3_s, f7_s, 1'b0);
                    state_s = S_WB_ALU;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUctl  = ALU_ADD;
                    state_s = (opcode_s == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    WBSel    = 2'b01;
                    state_s  = S_FETCH;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    state_s  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUctl  = ALU_SUB;
                    PCSrc   = 1'b1;
                    PCWrite = (f3_s == 3'b000) ? zero : ~zero;
                    state_s = S_FETCH;
                end
                S_JAL: begin
                    RegWrite = 1'b1;
                    WBSel    = 2'b10;
                    PCWrite  = 1'b1;
                    PCSrc    = 1'b1;
                    state_s  = S_FETCH;
                end
                S_TRAP: begin
                    state_s = S_TRAP;
                end
                default: begin
                    state_s = S_TRAP;
                end
            endcase
        end
    end

    assign illegal = illegal_r;
    assign timeout = timeout_r;
    assign state   = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one default instance plus one with JAL disabled.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite;
    logic [1:0]  WBSel, ALUSrcB;
    logic        ALUSrcA;
    logic [3:0]  ALUctl;
    logic        illegal, timeout;
    logic [3:0]  state;

    logic        n_PCWrite, n_PCSrc, n_IorD, n_IRWrite, n_MemRead, n_MemWrite, n_RegWrite;
    logic [1:0]  n_WBSel, n_ALUSrcB;
    logic        n_ALUSrcA;
    logic [3:0]  n_ALUctl;
    logic        n_illegal, n_timeout;
    logic [3:0]  n_state;

    int passed = 0;
    int total  = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .WBSel(WBSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctl(ALUctl),
        .illegal(illegal), .timeout(timeout), .state(state)
    );

    multicycle_control_unit #(.ENABLE_JAL(1'b0)) dut_nojal (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(n_PCWrite), .PCSrc(n_PCSrc), .IorD(n_IorD), .IRWrite(n_IRWrite),
        .MemRead(n_MemRead), .MemWrite(n_MemWrite), .RegWrite(n_RegWrite), .WBSel(n_WBSel),
        .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUctl(n_ALUctl),
        .illegal(n_illegal), .timeout(n_timeout), .state(n_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0000_0013; mem_ready = 1'b0; zero = 1'b0;
        tick(); tick();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);

        // ADD x3,x1,x2
        rst = 1'b0; instr = 32'h0020_81B3; mem_ready = 1'b1; #1;
        chk("add_fetch_state", {28'd0, state}, 32'd0);
        chk("add_fetch_strobes", {29'd0, MemRead, IRWrite, PCWrite}, 32'h7);
        chk("add_fetch_alu", {26'd0, ALUSrcB, ALUctl}, {26'd0, 2'b01, 4'b0010});
        tick();
        chk("add_decode", {26'd0, state, ALUSrcB}, {26'd0, 4'd1, 2'b10});
        chk("add_decode_rw", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("add_exec", {27'd0, state, ALUSrcA}, {27'd0, 4'd2, 1'b1});
        chk("add_exec_aluctl", {28'd0, ALUctl}, 32'h2);
        chk("add_exec_rw", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("add_wb", {25'd0, state, RegWrite, WBSel}, {25'd0, 4'd8, 1'b1, 2'b00});
        tick();
        chk("add_back_fetch", {28'd0, state}, 32'd0);

        // SUB and SRA
        instr = 32'h4020_81B3; tick(); tick();
        chk("sub_aluctl", {24'd0, state, ALUctl}, {24'd0, 4'd2, 4'b0110});
        tick(); tick();
        instr = 32'h4020_D1B3; tick(); tick();
        chk("sra_aluctl", {24'd0, state, ALUctl}, {24'd0, 4'd2, 4'b1010});
        tick(); tick();

        // SLTU is rejected
        chk("pre_sltu_fetch", {28'd0, state}, 32'd0);
        instr = 32'h0020_B1B3; tick(); tick();
        chk("sltu_trap", {27'd0, state, illegal}, {27'd0, 4'd11, 1'b1});
        tick();
        chk("trap_held", {28'd0, state}, 32'd11);
        chk("trap_strobes", {25'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, timeout, 1'b0}, 32'd0);

        // LW with three stalled cycles in MEM_RD
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_illegal", {31'd0, illegal}, 32'd0);
        instr = 32'h0000_A183; mem_ready = 1'b1;
        tick(); tick();
        chk("lw_memaddr", {24'd0, state, ALUctl}, {24'd0, 4'd4, 4'b0010});
        mem_ready = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready = 1'b1; #1;
            end
            chk("lw_memrd", {26'd0, state, MemRead, IorD}, {26'd0, 4'd5, 1'b1, 1'b1});
            tick();
        end
        chk("lw_wbmem", {25'd0, state, RegWrite, WBSel}, {25'd0, 4'd7, 1'b1, 2'b01});
        tick();
        chk("lw_done", {28'd0, state}, 32'd0);

        // BEQ / BNE with both zero values in the BRANCH cycle
        instr = 32'h0020_8463; tick(); tick();
        zero = 1'b1; #1;
        chk("beq_taken", {22'd0, state, PCWrite, PCSrc, ALUctl}, {22'd0, 4'd9, 1'b1, 1'b1, 4'b0110});
        zero = 1'b0; #1;
        chk("beq_not_taken", {31'd0, PCWrite}, 32'd0);
        tick();
        instr = 32'h0020_9463; tick(); tick();
        zero = 1'b0; #1;
        chk("bne_taken", {26'd0, state, PCWrite, PCSrc}, {26'd0, 4'd9, 1'b1, 1'b1});
        zero = 1'b1; #1;
        chk("bne_not_taken", {31'd0, PCWrite}, 32'd0);
        tick();

        // JAL supported vs disabled
        instr = 32'h0080_00EF; tick(); tick();
        chk("jal_state", {24'd0, state, RegWrite, PCWrite, PCSrc, 1'b0}, {24'd0, 4'd10, 4'b1110});
        chk("jal_wbsel", {30'd0, WBSel}, 32'h2);
        chk("nojal_trap", {27'd0, n_state, n_illegal}, {27'd0, 4'd11, 1'b1});
        tick();
        chk("jal_done", {28'd0, state}, 32'd0);

        // Fetch timeout after 16 stalled cycles
        rst = 1'b1; tick(); rst = 1'b0; mem_ready = 1'b0;
        repeat (15) tick();
        chk("to_still_fetch", {27'd0, state, timeout}, {27'd0, 4'd0, 1'b0});
        tick();
        chk("to_trap", {27'd0, state, timeout}, {27'd0, 4'd11, 1'b1});
        mem_ready = 1'b1; #1;
        chk("to_strobes", {27'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite}, 32'd0);
        tick();
        chk("to_held", {28'd0, state}, 32'd11);

        // Reset during MEM_WR
        rst = 1'b1; tick(); rst = 1'b0;
        instr = 32'h0020_A023; mem_ready = 1'b1; tick(); tick();
        mem_ready = 1'b0; tick();
        chk("sw_memwr", {26'd0, state, MemWrite, IorD}, {26'd0, 4'd6, 1'b1, 1'b1});
        rst = 1'b1; #1;
        chk("sw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        chk("sw_rst_state", {28'd0, state}, 32'd0);
        rst = 1'b0; tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
